// File: rtl/rom_read_arbiter_if.sv
`timescale 1ns/1ps
// rom_read_arbiter_if
//  Bundles the two requester ports, the shared read-data bus and the ROM
//  control/data pins of rom_read_arbiter.
//  Modports:
//    slave  - the arbiter: samples requests and ROM data, drives grants,
//             read-valid pulses, rdata, busy and the ROM control pins.
//    master - everything around it (requesters plus the ROM instance).
//  Signals:
//    req0/addr0, req1/addr1   read requests and their addresses
//    gnt0/gnt1                1-cycle pulse: request accepted
//    rvalid0/rvalid1          1-cycle pulse: rdata holds that port's word
//    rdata                    shared read-data bus, holds last captured word
//    busy                     arbiter not idle
//    rom_en/rom_addr          to the ROM
//    rom_out                  from the ROM
interface rom_read_arbiter_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              req0;
  logic [ADDR_W-1:0] addr0;
  logic              gnt0;
  logic              rvalid0;
  logic              req1;
  logic [ADDR_W-1:0] addr1;
  logic              gnt1;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_out;

  modport slave (
    input  req0, addr0, req1, addr1, rom_out,
    output gnt0, rvalid0, gnt1, rvalid1, rdata, busy, rom_en, rom_addr
  );

  modport master (
    output req0, addr0, req1, addr1, rom_out,
    input  gnt0, rvalid0, gnt1, rvalid1, rdata, busy, rom_en, rom_addr
  );
endinterface

// File: rtl/rom_read_arbiter.sv
`timescale 1ns/1ps
// rom_read_arbiter
//  Shares one synchronous ROM between two read requesters. Round-robin
//  arbitration with a single outstanding read; every output is registered.
//  Sequence per read: IDLE (grant) -> ISSUE (one cycle, ROM strobed)
//  -> WAIT (ROM_LAT cycles) -> capture into rdata with a per-port valid pulse.
//  Ports:
//    clk  - system clock, rising edge
//    rst  - synchronous active-high reset
//    bus  - rom_read_arbiter_if.slave: requests, grants, read-valids,
//           rdata, busy and the ROM en/address/data pins
//  Parameters:
//    ADDR_W  ROM address width
//    DATA_W  ROM data width
//    ROM_LAT ROM read latency in cycles, 1..3
module rom_read_arbiter #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  rom_read_arbiter_if.slave  bus
);

  localparam int CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fav_q, fav_d;      // 0: port 0 favoured, 1: port 1 favoured
  logic              owner_q, owner_d;  // port whose read is in flight
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic              rom_en_q, rom_en_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              pick;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fav_d      = fav_q;
    owner_d    = owner_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    rdata_d    = rdata_q;
    pick       = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          // Contention goes to the favoured port; a lone request wins outright.
          pick       = (bus.req0 && bus.req1) ? fav_q : bus.req1;
          owner_d    = pick;
          fav_d      = ~pick;
          gnt0_d     = ~pick;
          gnt1_d     = pick;
          rom_en_d   = 1'b1;
          rom_addr_d = pick ? bus.addr1 : bus.addr0;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // The ROM sampled en/addr at the edge that entered WAIT, so ROM_LAT
        // more edges bring its data; cnt counts them down to the capture edge.
        cnt_d   = CNT_W'(ROM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rdata_d   = bus.rom_out;
          rvalid0_d = ~owner_q;
          rvalid1_d = owner_q;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fav_q      <= 1'b0;
      owner_q    <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fav_q      <= fav_d;
      owner_q    <= owner_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt0     = gnt0_q;
  assign bus.gnt1     = gnt1_q;
  assign bus.rvalid0  = rvalid0_q;
  assign bus.rvalid1  = rvalid1_q;
  assign bus.rom_en   = rom_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
`timescale 1ns/1ps
// Two arbiters (ROM_LAT=1 in lane 0, ROM_LAT=3 in lane 1) share one stimulus
// stream; each has its own ROM model and its own transaction-level reference.
module tb_rom_read_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, req1;
  logic [3:0]  addr0, addr1;

  logic [1:0]  g0_w, g1_w, rv0_w, rv1_w, en_w, busy_w;
  logic [3:0]  ra_w [2];
  logic [15:0] rd_w [2];

  int pass_cnt  = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_word(input logic [3:0] a);
    return {a, a, a, a};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      localparam int LAT = (gi == 0) ? 1 : 3;
      rom_read_arbiter_if #(.ADDR_W(4), .DATA_W(16)) bus ();
      logic [15:0] pipe [LAT];

      rom_read_arbiter #(.ADDR_W(4), .DATA_W(16), .ROM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
      );

      assign bus.req0  = req0;
      assign bus.addr0 = addr0;
      assign bus.req1  = req1;
      assign bus.addr1 = addr1;

      // ROM: LAT-cycle registered read, output holds while en is low.
      always @(posedge clk) begin
        pipe[0] <= bus.rom_en ? rom_word(bus.rom_addr) : pipe[0];
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign bus.rom_out = pipe[LAT-1];

      assign g0_w[gi]   = bus.gnt0;
      assign g1_w[gi]   = bus.gnt1;
      assign rv0_w[gi]  = bus.rvalid0;
      assign rv1_w[gi]  = bus.rvalid1;
      assign en_w[gi]   = bus.rom_en;
      assign busy_w[gi] = bus.busy;
      assign ra_w[gi]   = bus.rom_addr;
      assign rd_w[gi]   = bus.rdata;
    end
  endgenerate

  // Reference model: "edges remaining until the read returns" per lane.
  int          rem_m  [2];
  bit          fav_m  [2];
  bit          own_m  [2];
  logic [3:0]  ra_m   [2];
  logic [15:0] rd_m   [2];
  bit          g0_m [2], g1_m [2], rv0_m [2], rv1_m [2], en_m [2], busy_m [2];
  bit          verbose = 1'b1;

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  task automatic model_step();
    bit x;
    for (int l = 0; l < 2; l++) begin
      g0_m[l] = 0; g1_m[l] = 0; rv0_m[l] = 0; rv1_m[l] = 0; en_m[l] = 0;
      if (rst) begin
        rem_m[l] = 0; fav_m[l] = 0; ra_m[l] = '0; rd_m[l] = '0;
      end else if (rem_m[l] == 0) begin
        if (req0 || req1) begin
          x = (req0 && req1) ? fav_m[l] : req1;
          own_m[l] = x;
          fav_m[l] = !x;
          if (x) g1_m[l] = 1; else g0_m[l] = 1;
          en_m[l]  = 1;
          ra_m[l]  = x ? addr1 : addr0;
          rem_m[l] = lat_of(l) + 1;
        end
      end else begin
        rem_m[l]--;
        if (rem_m[l] == 0) begin
          rd_m[l] = 16'(ra_m[l]) * 16'h1111;
          if (own_m[l]) rv1_m[l] = 1; else rv0_m[l] = 1;
        end
      end
      busy_m[l] = (rem_m[l] != 0);
    end
  endtask

  task automatic chk(input string nm, input int l, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, l, act, exp, $time);
    else
      pass_cnt++;
  endtask

  task automatic compare();
    for (int l = 0; l < 2; l++) begin
      chk("gnt0",     l, {31'b0, g0_w[l]},   {31'b0, g0_m[l]});
      chk("gnt1",     l, {31'b0, g1_w[l]},   {31'b0, g1_m[l]});
      chk("rvalid0",  l, {31'b0, rv0_w[l]},  {31'b0, rv0_m[l]});
      chk("rvalid1",  l, {31'b0, rv1_w[l]},  {31'b0, rv1_m[l]});
      chk("rom_en",   l, {31'b0, en_w[l]},   {31'b0, en_m[l]});
      chk("busy",     l, {31'b0, busy_w[l]}, {31'b0, busy_m[l]});
      chk("rom_addr", l, {28'b0, ra_w[l]},   {28'b0, ra_m[l]});
      chk("rdata",    l, {16'b0, rd_w[l]},   {16'b0, rd_m[l]});
      if (verbose && (rv0_w[l] || rv1_w[l]))
        $display("lane%0d read port%0d rdata=%h at %0t", l, rv1_w[l], rd_w[l], $time);
    end
  endtask

  // One clock: model follows the edge, DUT outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  int gport [8];
  int gtime [8];
  int gn;
  int bc;
  int cnt_g0, cnt_rv0;

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
    tick();
    chk("rst_busy",  0, {31'b0, busy_w[0]}, 32'd0);
    chk("rst_rdata", 1, {16'b0, rd_w[1]},   32'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single read, port 0, address 5
    req0 = 1'b1; addr0 = 4'd5;
    tick();
    chk("t1_gnt0",     0, {31'b0, g0_w[0]}, 32'd1);
    chk("t1_rom_en",   0, {31'b0, en_w[0]}, 32'd1);
    chk("t1_rom_addr", 0, {28'b0, ra_w[0]}, 32'd5);
    req0 = 1'b0;
    tick();
    chk("t1_no_early_rv", 0, {31'b0, rv0_w[0]}, 32'd0);
    tick();
    chk("t1_rvalid0", 0, {31'b0, rv0_w[0]}, 32'd1);
    chk("t1_rdata",   0, {16'b0, rd_w[0]},  32'h5555);
    tick(); tick();
    chk("t1_lat3_rvalid0", 1, {31'b0, rv0_w[1]}, 32'd1);
    chk("t1_lat3_rdata",   1, {16'b0, rd_w[1]},  32'h5555);
    tick(); tick();

    // 2: simultaneous requests right after reset, port 0 first
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; addr0 = 4'd3; req1 = 1'b1; addr1 = 4'd12;
    tick();                                   // E0
    chk("t2_gnt0", 0, {31'b0, g0_w[0]}, 32'd1);
    chk("t2_gnt1", 0, {31'b0, g1_w[0]}, 32'd0);
    req0 = 1'b0;
    tick();                                   // E1
    tick();                                   // E2
    chk("t2_rv0",    0, {31'b0, rv0_w[0]}, 32'd1);
    chk("t2_rdata0", 0, {16'b0, rd_w[0]},  32'h3333);
    tick();                                   // E3
    chk("t2_gnt1_late", 0, {31'b0, g1_w[0]}, 32'd1);
    tick();                                   // E4
    tick();                                   // E5
    chk("t2_rv1",    0, {31'b0, rv1_w[0]}, 32'd1);
    chk("t2_rdata1", 0, {16'b0, rd_w[0]},  32'hCCCC);
    req1 = 1'b0;
    tick(); tick(); tick();
    tick();                                   // E9
    chk("t2_lat3_rv1",   1, {31'b0, rv1_w[1]}, 32'd1);
    chk("t2_lat3_rdata", 1, {16'b0, rd_w[1]},  32'hCCCC);
    tick(); tick();

    // 3: both held high -> lane 0 grants alternate every 3 cycles
    req0 = 1'b1; addr0 = 4'd2; req1 = 1'b1; addr1 = 4'd10;
    gn = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if ((g0_w[0] || g1_w[0]) && gn < 8) begin
        gport[gn] = g1_w[0] ? 1 : 0;
        gtime[gn] = t;
        gn++;
      end
    end
    chk("t3_grant_count", 0, 32'(gn), 32'd4);
    for (int i = 0; i < 4 && i < gn; i++) begin
      chk("t3_grant_port", 0, 32'(gport[i]), 32'(i % 2));
      chk("t3_grant_time", 0, 32'(gtime[i]), 32'(3 * i));
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int t = 0; t < 6; t++) tick();

    // 4: reset while waiting on a port 1 read
    req1 = 1'b1; addr1 = 4'd9;
    tick();                                   // E0
    chk("t4_gnt1", 0, {31'b0, g1_w[0]}, 32'd1);
    req1 = 1'b0;
    tick();                                   // E1
    chk("t4_rdata_before", 0, {16'b0, rd_w[0]}, 32'hAAAA);
    rst = 1'b1;
    tick();                                   // E2
    chk("t4_no_rv1", 0, {31'b0, rv1_w[0]},  32'd0);
    chk("t4_rdata0", 0, {16'b0, rd_w[0]},   32'd0);
    chk("t4_busy",   0, {31'b0, busy_w[0]}, 32'd0);
    chk("t4_busy",   1, {31'b0, busy_w[1]}, 32'd0);
    rst = 1'b0;
    req0 = 1'b1; addr0 = 4'd7;
    tick();
    req0 = 1'b0;
    tick(); tick();
    chk("t4_after_rv0",   0, {31'b0, rv0_w[0]}, 32'd1);
    chk("t4_after_rdata", 0, {16'b0, rd_w[0]},  32'h7777);
    tick(); tick(); tick();

    // 5: ROM_LAT=3 lane, port 1, address 15
    req1 = 1'b1; addr1 = 4'd15;
    bc = 0;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (t == 0) req1 = 1'b0;
      bc += int'(busy_w[1]);
      if (t == 4) begin
        chk("t5_rv1",   1, {31'b0, rv1_w[1]}, 32'd1);
        chk("t5_rdata", 1, {16'b0, rd_w[1]},  32'hFFFF);
      end
    end
    chk("t5_busy_cycles", 1, 32'(bc), 32'd4);

    // 6: port 0 pulse while busy, gone before IDLE -> nothing for port 0
    req1 = 1'b1; addr1 = 4'd4;
    tick();
    req1 = 1'b0; req0 = 1'b1; addr0 = 4'd6;
    cnt_g0 = 0; cnt_rv0 = 0;
    for (int t = 0; t < 7; t++) begin
      tick();
      if (t == 0) req0 = 1'b0;
      cnt_g0  += int'(g0_w[0]) + int'(g0_w[1]);
      cnt_rv0 += int'(rv0_w[0]) + int'(rv0_w[1]);
    end
    chk("t6_no_gnt0",   0, 32'(cnt_g0),  32'd0);
    chk("t6_no_rvalid0", 0, 32'(cnt_rv0), 32'd0);

    // Random traffic with occasional resets, checked against the model
    verbose = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      rst   = ($urandom_range(0, 199) == 0);
      req0  = ($urandom_range(0, 2) != 0);
      req1  = ($urandom_range(0, 2) != 0);
      addr0 = 4'($urandom_range(0, 15));
      addr1 = 4'($urandom_range(0, 15));
      tick();
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    for (int t = 0; t < 6; t++) tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
